// File: rtl/rowcol_pkg.sv
// Shared types and helpers for the row/column AER interface.
//   state_e   : per-channel handshake FSM state (IDLE/REQ/GRANT/REL).
//   cnt_width : width of a pending-spike counter able to hold 0..depth.
package rowcol_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGrant,
    StRel
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rowcol_interface_n_if.sv
// Bundle of handshake signals between the row/column interface and its environment.
//   greedy, aer_dis          : mode controls
//   n_p                      : per-channel spike inputs, active-low, asynchronous
//   n_ai, arbtop_n_ri        : shared acknowledge / arbiter-top grant, active-low
//   n_ri                     : per-channel arbiter grant, active-low
//   ro, s, ao                : per-channel request / select / acknowledge, active-high
// master: environment side (drives inputs). slave: block side.
interface rowcol_interface_n_if #(
  parameter int unsigned N_CH = 16
);
  logic            greedy;
  logic            aer_dis;
  logic [N_CH-1:0] n_p;
  logic            n_ai;
  logic [N_CH-1:0] n_ri;
  logic            arbtop_n_ri;
  logic [N_CH-1:0] ro;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] ao;

  modport master (
    output greedy, aer_dis, n_p, n_ai, n_ri, arbtop_n_ri,
    input  ro, s, ao
  );

  modport slave (
    input  greedy, aer_dis, n_p, n_ai, n_ri, arbtop_n_ri,
    output ro, s, ao
  );
endinterface

// File: rtl/rowcol_channel.sv
// One row/column channel: n_p synchroniser, falling-edge spike detector,
// saturating pending counter and the IDLE/REQ/GRANT/REL handshake FSM.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   greedy_i, aer_dis_i            : mode controls
//   n_p_i                          : raw spike input, active-low, asynchronous
//   n_ai_i, n_ri_i, arbtop_n_ri_i  : acknowledge / grants, active-low
//   ro_o, s_o, ao_o                : registered request / select / acknowledge
//   ovf_o                          : sticky overflow (only with ROWCOL_OVF_EN)
// Macro ROWCOL_OVF_EN adds the ovf_o output and its logic.
module rowcol_channel
  import rowcol_pkg::*;
#(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic greedy_i,
  input  logic aer_dis_i,
  input  logic n_p_i,
  input  logic n_ai_i,
  input  logic n_ri_i,
  input  logic arbtop_n_ri_i,
`ifdef ROWCOL_OVF_EN
  output logic ovf_o,
`endif
  output logic ro_o,
  output logic s_o,
  output logic ao_o
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic                   ro_q, ro_d, s_q, s_d, ao_q, ao_d;
  logic                   spike;
  logic                   dec;

  // Synchroniser idles high; a spike is a 1->0 step at its output.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], n_p_i};
    prev_d = sync_q[SYNC_STAGES-1];
    spike  = prev_q & ~sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d = state_q;
    dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cnt_q != '0 && !aer_dis_i) state_d = StReq;
      end
      StReq: begin
        if (!n_ri_i) state_d = StGrant;
      end
      StGrant: begin
        // aer_dis is ignored here so an in-flight handshake always completes.
        if (!n_ai_i) begin
          state_d = StRel;
          dec     = 1'b1;
        end
      end
      StRel: begin
        if (n_ri_i && n_ai_i) begin
          if (greedy_i && cnt_q != '0 && !aer_dis_i && !arbtop_n_ri_i) state_d = StReq;
          else state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Simultaneous spike and decrement cancel, even when saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (spike && !dec) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
    end else if (!spike && dec) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Outputs decoded from the next state and registered, so they never glitch.
  always_comb begin
    ro_d = (state_d == StReq) || (state_d == StGrant);
    s_d  = (state_d == StGrant);
    ao_d = (state_d == StGrant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      state_q <= StIdle;
      ro_q    <= 1'b0;
      s_q     <= 1'b0;
      ao_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ro_q    <= ro_d;
      s_q     <= s_d;
      ao_q    <= ao_d;
    end
  end

  assign ro_o = ro_q;
  assign s_o  = s_q;
  assign ao_o = ao_q;

`ifdef ROWCOL_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (spike & ~dec & (cnt_q == CntMax));
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/rowcol_interface_n.sv
// Row/column AER interface: N_CH independent channels, each buffering up to
// DEPTH spikes and handshaking them out through the arbiter/encoder.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : rowcol_interface_n_if slave modport (greedy, aer_dis, n_p, n_ai,
//              n_ri, arbtop_n_ri in; ro, s, ao out)
//   ovf      : per-channel sticky overflow (only with ROWCOL_OVF_EN)
// Macro ROWCOL_OVF_EN adds the ovf port.
module rowcol_interface_n #(
  parameter int unsigned N_CH        = 16,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
`ifdef ROWCOL_OVF_EN
  output logic [N_CH-1:0] ovf,
`endif
  rowcol_interface_n_if.slave bus
);

  logic [N_CH-1:0] ro_w, s_w, ao_w;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rowcol_channel #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .greedy_i      (bus.greedy),
      .aer_dis_i     (bus.aer_dis),
      .n_p_i         (bus.n_p[g]),
      .n_ai_i        (bus.n_ai),
      .n_ri_i        (bus.n_ri[g]),
      .arbtop_n_ri_i (bus.arbtop_n_ri),
`ifdef ROWCOL_OVF_EN
      .ovf_o         (ovf[g]),
`endif
      .ro_o          (ro_w[g]),
      .s_o           (s_w[g]),
      .ao_o          (ao_w[g])
    );
  end

  assign bus.ro = ro_w;
  assign bus.s  = s_w;
  assign bus.ao = ao_w;

endmodule

// File: doc/rowcol_interface_n.md
ROWCOL_INTERFACE_N -- requirements
Module: rowcol_interface_n

Interface
REQ-001 SHALL have parameter N_CH, default 16: number of row/column channels.
REQ-002 SHALL have parameter DEPTH, default 3: pending spikes buffered per channel, range 1..15.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops on each n_p input, range 2..3.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port greedy, input, 1: enables back-to-back re-request without returning to IDLE.
REQ-007 SHALL have port aer_dis, input, 1: blocks new requests; spikes are still counted.
REQ-008 SHALL have port n_p, input, N_CH: per-channel spike, active-low, asynchronous.
REQ-009 SHALL have port n_ai, input, 1: shared acknowledge from the downstream encoder, active-low.
REQ-010 SHALL have port n_ri, input, N_CH: per-channel grant from the arbiter, active-low.
REQ-011 SHALL have port arbtop_n_ri, input, 1: arbiter-top grant, active-low; qualifies greedy re-request.
REQ-012 SHALL have port ro, output, N_CH: per-channel request to the arbiter, active-high, registered.
REQ-013 SHALL have port s, output, N_CH: per-channel select to the address encoder, active-high, registered.
REQ-014 SHALL have port ao, output, N_CH: per-channel acknowledge back to the pixel side, active-high, registered.

Function
REQ-015 Each n_p[i] SHALL pass through a SYNC_STAGES synchroniser.
REQ-016 A high-to-low transition at the synchroniser output SHALL be one spike event.
REQ-017 Each channel SHALL hold a pending counter cnt[i] of width clog2(DEPTH+1).
- A spike event increments cnt[i].
- A completed handshake decrements cnt[i].
REQ-018 Spike event and decrement in the same cycle SHALL leave cnt[i] unchanged, including at cnt[i]==DEPTH.
REQ-019 A spike event at cnt[i]==DEPTH with no decrement SHALL be dropped; cnt[i] stays at DEPTH.
REQ-020 Each channel SHALL run an FSM with states IDLE, REQ, GRANT, REL.
REQ-021 IDLE->REQ SHALL occur when cnt[i]>0 and aer_dis==0.
REQ-022 In REQ, ro[i]=1. REQ->GRANT SHALL occur when n_ri[i]==0.
REQ-023 In GRANT, ro[i]=s[i]=ao[i]=1. GRANT->REL SHALL occur when n_ai==0.
- On this transition cnt[i] decrements.
REQ-024 In REL, ro[i]=s[i]=ao[i]=0.
- REL is left only when n_ri[i]==1 and n_ai==1.
- Exit goes to REQ if greedy==1, cnt[i]>0, aer_dis==0 and arbtop_n_ri==0; otherwise to IDLE.
REQ-025 Timing, with edge 0 being the first edge at which n_p[i] is sampled low:
- cnt[i] SHALL increment at edge SYNC_STAGES.
- ro[i] SHALL rise at edge SYNC_STAGES+1.
REQ-026 aer_dis SHALL gate only IDLE->REQ and the REL->REQ re-request; an in-flight handshake completes normally.
REQ-027 Channels SHALL be independent. n_ai is shared, but only a channel in GRANT reacts to it.

Reset
REQ-028 While rst==1 at a clock edge, the block SHALL:
- force all FSMs to IDLE;
- clear all cnt and synchroniser flops (synchroniser flops to 1, i.e. idle-high);
- drive ro=s=ao=0 on the next edge.
REQ-029 rst asserted mid-handshake SHALL abort the handshake and discard all pending spikes, with no glitch on the outputs.

Configuration
REQ-030 With macro ROWCOL_OVF_EN defined, the block SHALL add output port ovf, N_CH bits.
- ovf[i] sets on a dropped spike (REQ-019) and is sticky until rst.
REQ-031 Without ROWCOL_OVF_EN, the ovf port and its logic SHALL be absent; dropped spikes are silent.

Structure
REQ-032 Package rowcol_pkg SHALL hold:
- the FSM state enum (IDLE/REQ/GRANT/REL);
- a count-width function clog2(DEPTH+1).
REQ-033 Sub-module rowcol_channel SHALL implement one channel (synchroniser, counter, FSM).
- The top generates N_CH instances of it.

Verification
REQ-034 Single spike, SYNC_STAGES=2: n_p[3] low at edge 0 -> cnt[3]=1 at edge 2, ro[3]=1 at edge 3. Then n_ri[3]=0 -> s[3]=ao[3]=1 next edge; n_ai=0 -> all low next edge, cnt[3]=0.
REQ-035 Overflow, DEPTH=3, grant held off: 5 spikes on channel 0 -> cnt[0]=3; ovf[0]=1 if ROWCOL_OVF_EN; 3 handshakes then ro[0] stays 0.
REQ-036 Greedy: greedy=1, arbtop_n_ri=0, cnt[1]=2 -> REL goes straight to REQ with no IDLE cycle; with greedy=0, one IDLE cycle occurs.
REQ-037 aer_dis=1 with 2 spikes on channel 5 -> ro[5]=0 and cnt[5]=2; deassert -> ro[5]=1 next edge. aer_dis raised in GRANT -> handshake completes.
REQ-038 Simultaneous events: spike on channel 2 in the same cycle as its GRANT->REL with cnt[2]=3 -> cnt[2]=3 and no ovf. rst during GRANT -> ro=s=ao=0 and cnt=0 next edge.
